// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a shared Montgomery multiplier.
// Routes operands and counts exponent bits; all arithmetic happens in the multiplier.
module montgomery_exp_ctrl #(
    parameter int unsigned W  = 128,
    parameter int unsigned EW = 128
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_in_valid,
    output logic          io_in_ready,
    input  logic [W-1:0]  io_in_base,
    input  logic [EW-1:0] io_in_exp,
    input  logic [W-1:0]  io_in_one,
    output logic          io_out_valid,
    input  logic          io_out_ready,
    output logic [W-1:0]  io_out_result,
    output logic          io_busy,
    output logic          io_mm_req,
    output logic [W-1:0]  io_mm_a,
    output logic [W-1:0]  io_mm_b,
    input  logic          io_mm_done,
    input  logic [W-1:0]  io_mm_res
);

    localparam int unsigned CntW = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(EW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StSqr,
        StSqrWait,
        StMul,
        StMulWait,
        StNext,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    base_q, base_d;
    logic [W-1:0]    one_q, one_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            exp_bit;

    assign exp_bit = exp_q[cnt_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            one_q   <= '0;
            acc_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            one_q   <= one_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        one_d   = one_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (io_in_valid) begin
                    base_d  = io_in_base;
                    exp_d   = io_in_exp;
                    one_d   = io_in_one;
                    cnt_d   = CntMax;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Reaching bit 0 with no set bit found means exp == 0.
                if (exp_bit) begin
                    acc_d = base_q;
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = StSqr;
                    end
                end else if (cnt_q == '0) begin
                    acc_d   = one_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSqr: begin
                state_d = StSqrWait;
            end
            StSqrWait: begin
                if (io_mm_done) begin
                    acc_d   = io_mm_res;
                    state_d = exp_bit ? StMul : StNext;
                end
            end
            StMul: begin
                state_d = StMulWait;
            end
            StMulWait: begin
                if (io_mm_done) begin
                    acc_d   = io_mm_res;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = StSqr;
                end
            end
            StDone: begin
                if (io_out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operands derive from registers that only change on the done edge, so they
    // stay stable from the request cycle through the done cycle.
    always_comb begin
        io_mm_a = '0;
        io_mm_b = '0;
        unique case (state_q)
            StSqr, StSqrWait: begin
                io_mm_a = acc_q;
                io_mm_b = acc_q;
            end
            StMul, StMulWait: begin
                io_mm_a = acc_q;
                io_mm_b = base_q;
            end
            default: ;
        endcase
    end

    assign io_in_ready   = (state_q == StIdle) && !reset;
    assign io_busy       = (state_q != StIdle);
    assign io_out_valid  = (state_q == StDone);
    assign io_out_result = (state_q == StDone) ? acc_q : '0;
    assign io_mm_req     = (state_q == StSqr) || (state_q == StMul);

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Scoreboard bench for montgomery_exp_ctrl with a mod-97 multiplier model of
// programmable latency and optional spurious done pulses.
module tb_montgomery_exp_ctrl;

    localparam int unsigned W  = 128;
    localparam int unsigned EW = 128;
    localparam logic [W-1:0] Mod = 97;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_in_valid = 1'b0;
    logic          io_in_ready;
    logic [W-1:0]  io_in_base = '0;
    logic [EW-1:0] io_in_exp = '0;
    logic [W-1:0]  io_in_one = '0;
    logic          io_out_valid;
    logic          io_out_ready = 1'b1;
    logic [W-1:0]  io_out_result;
    logic          io_busy;
    logic          io_mm_req;
    logic [W-1:0]  io_mm_a;
    logic [W-1:0]  io_mm_b;
    logic          io_mm_done = 1'b0;
    logic [W-1:0]  io_mm_res = '0;

    montgomery_exp_ctrl #(.W(W), .EW(EW)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_base    (io_in_base),
        .io_in_exp     (io_in_exp),
        .io_in_one     (io_in_one),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_result (io_out_result),
        .io_busy       (io_busy),
        .io_mm_req     (io_mm_req),
        .io_mm_a       (io_mm_a),
        .io_mm_b       (io_mm_b),
        .io_mm_done    (io_mm_done),
        .io_mm_res     (io_mm_res)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        int           ops;
        int           busy;
    } exp_t;

    exp_t           sb[$];
    logic [2*W-1:0] pairs[$];

    int n_checks = 0;
    int n_errors = 0;

    int unsigned lat      = 3;
    bit          spur_en  = 1'b0;
    bit          chk_opnd = 1'b1;

    task automatic check_val(input string tag, input logic [2*W-1:0] act,
                             input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: right-to-left exponentiation mod 97 (bases kept below 97).
    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [EW-1:0] e,
                                             input logic [W-1:0] one);
        logic [W-1:0] r;
        logic [W-1:0] p;
        if (e == '0) return one;
        r = 1;
        p = b % Mod;
        for (int i = 0; i < int'(EW); i++) begin
            if (e[i]) r = (r * p) % Mod;
            p = (p * p) % Mod;
        end
        return r;
    endfunction

    function automatic int ref_ops(input logic [EW-1:0] e);
        int top = 0;
        int pc  = 0;
        for (int i = 0; i < int'(EW); i++) begin
            if (e[i]) begin
                top = i;
                pc++;
            end
        end
        return (pc == 0) ? 0 : top + pc - 1;
    endfunction

    // Multiplier model, operand/request checker and output monitor.
    int unsigned  mdl_cnt   = 0;
    logic [W-1:0] cap_a     = '0;
    logic [W-1:0] cap_b     = '0;
    bit           prev_req  = 1'b0;
    int           ops_seen  = 0;
    int           busy_run  = 0;

    always @(negedge clock) begin
        bit   fired;
        exp_t e;
        fired      = 1'b0;
        io_mm_done = 1'b0;
        if (mdl_cnt > 0) begin
            if (chk_opnd) check_val("mm_opnd_stable", {io_mm_a, io_mm_b}, {cap_a, cap_b});
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                io_mm_done = 1'b1;
                io_mm_res  = (cap_a * cap_b) % Mod;
                fired      = 1'b1;
            end
        end
        if (io_mm_req === 1'b1) begin
            check_val("mm_req_single", (prev_req || mdl_cnt != 0), 0);
            ops_seen++;
            cap_a   = io_mm_a;
            cap_b   = io_mm_b;
            mdl_cnt = lat;
            if (pairs.size() != 0) check_val("mm_pair", {io_mm_a, io_mm_b}, pairs.pop_front());
        end else if (spur_en && !fired && mdl_cnt == 0 && $urandom_range(0, 2) == 0) begin
            io_mm_done = 1'b1;
            io_mm_res  = W'($urandom);
        end
        prev_req = (io_mm_req === 1'b1);

        if (io_busy !== 1'b1) begin
            ops_seen = 0;
            busy_run = 0;
        end else begin
            busy_run++;
            if (io_out_valid && io_out_ready) begin
                check_val("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_val("result", io_out_result, e.res);
                    check_val("mm_ops", ops_seen, e.ops);
                    if (e.busy >= 0) check_val("busy_cycles", busy_run, e.busy);
                end
                ops_seen = 0;
                busy_run = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] one,
                        input bit push, input bit chk_busy);
        int   guard = 0;
        exp_t x;
        @(negedge clock);
        while (!io_in_ready && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        check_val("in_ready_wait", io_in_ready, 1);
        io_in_valid = 1'b1;
        io_in_base  = b;
        io_in_exp   = e;
        io_in_one   = one;
        if (push) begin
            x.res  = ref_pow(b, e, one);
            x.ops  = ref_ops(e);
            x.busy = chk_busy ? int'(EW) + 1 + x.ops * (int'(lat) + 1) : -1;
            sb.push_back(x);
        end
        @(negedge clock);
        io_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        check_val("drain_timeout", (sb.size() == 0), 1);
        check_val("pairs_consumed", pairs.size(), 0);
    endtask

    task automatic push_pairs_11();
        pairs.push_back({W'(5), W'(5)});
        pairs.push_back({W'(25), W'(25)});
        pairs.push_back({W'(43), W'(5)});
        pairs.push_back({W'(21), W'(21)});
        pairs.push_back({W'(53), W'(5)});
    endtask

    initial begin
        int guard;
        logic [EW-1:0] top_bit;

        // Reset values
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_val("in_ready_in_reset", io_in_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_in_ready", io_in_ready, 1);
        check_val("rst_out_valid", io_out_valid, 0);
        check_val("rst_busy", io_busy, 0);
        check_val("rst_mm_req", io_mm_req, 0);
        check_val("rst_result", io_out_result, 0);
        check_val("rst_mm_ab", {io_mm_a, io_mm_b}, 0);

        // base=5, exp=11, L=3 -> 71 with the known operand schedule
        lat = 3;
        push_pairs_11();
        send(5, 11, 1, 1'b1, 1'b1);
        wait_drain();

        // exp=0 returns one without touching the multiplier
        send(17, 0, 1, 1'b1, 1'b1);
        wait_drain();

        // exp=1 returns base
        send(42, 1, 1, 1'b1, 1'b1);
        wait_drain();

        // Single top bit: EW-1 squarings only
        lat = 1;
        top_bit = EW'(1) << (EW - 1);
        send(2, top_bit, 1, 1'b1, 1'b1);
        wait_drain();

        // Back-pressure, plus requests offered while busy must be ignored
        lat = 2;
        io_out_ready = 1'b0;
        send(3, 5, 1, 1'b1, 1'b0);
        io_in_valid = 1'b1;
        io_in_base  = 7;
        io_in_exp   = 3;
        repeat (4) @(negedge clock);
        io_in_valid = 1'b0;
        guard = 0;
        while (!io_out_valid && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_val("bp_valid_held", io_out_valid, 1);
            check_val("bp_result_held", io_out_result, ref_pow(3, 5, 1));
            check_val("bp_in_ready_low", io_in_ready, 0);
        end
        io_out_ready = 1'b1;
        wait_drain();

        // Reset while waiting on a multiply; the stale done must be ignored
        lat = 3;
        send(5, 11, 1, 1'b0, 1'b0);
        guard = 0;
        while (!(io_mm_req && io_mm_a == 43) && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        check_val("reached_mul", {io_mm_a, io_mm_b}, {W'(43), W'(5)});
        chk_opnd = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("abort_in_ready", io_in_ready, 1);
        check_val("abort_busy", io_busy, 0);
        check_val("abort_mm_req", io_mm_req, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_val("abort_out_valid", io_out_valid, 0);
            check_val("abort_idle", io_busy, 0);
        end
        chk_opnd = 1'b1;
        push_pairs_11();
        send(5, 11, 1, 1'b1, 1'b1);
        wait_drain();

        // Spurious done pulses with short and long multiplier latency
        spur_en = 1'b1;
        repeat (8) @(negedge clock);
        lat = 1;
        push_pairs_11();
        send(5, 11, 1, 1'b1, 1'b1);
        wait_drain();
        lat = 8;
        push_pairs_11();
        send(5, 11, 1, 1'b1, 1'b1);
        wait_drain();
        send(9, 0, 1, 1'b1, 1'b1);
        wait_drain();
        spur_en = 1'b0;
        repeat (4) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
